// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - response codes and handshake FSM encodings for the AXI4-Lite register file
package axil_pkg;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/axil_slave_regfile_if.sv
// rtl/axil_slave_regfile_if.sv - AXI4-Lite channel bundle between bus master and register file
interface axil_slave_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr;
  logic                    s1_axi_awvalid;
  logic                    s1_axi_awready;
  logic [DATA_WIDTH-1:0]   s1_axi_wdata;
  logic [DATA_WIDTH/8:0]   s1_axi_wstrb;
  logic                    s1_axi_wvalid;
  logic                    s1_axi_wready;
  logic                    s1_axi_bresp;
  logic                    s1_axi_bvalid;
  logic                    s1_axi_bready;
  logic [ADDR_WIDTH-1:0]   s1_axi_araddr;
  logic                    s1_axi_arvalid;
  logic                    s1_axi_arready;
  logic [DATA_WIDTH-1:0]   s1_axi_rdata;
  logic                    s1_axi_rresp;
  logic                    s1_axi_rvalid;
  logic                    s1_axi_rready;

  modport master (
    output s1_axi_awaddr, s1_axi_awvalid, s1_axi_wdata, s1_axi_wstrb, s1_axi_wvalid,
           s1_axi_bready, s1_axi_araddr, s1_axi_arvalid, s1_axi_rready,
    input  s1_axi_awready, s1_axi_wready, s1_axi_bresp, s1_axi_bvalid,
           s1_axi_arready, s1_axi_rdata, s1_axi_rresp, s1_axi_rvalid
  );

  modport slave (
    input  s1_axi_awaddr, s1_axi_awvalid, s1_axi_wdata, s1_axi_wstrb, s1_axi_wvalid,
           s1_axi_bready, s1_axi_araddr, s1_axi_arvalid, s1_axi_rready,
    output s1_axi_awready, s1_axi_wready, s1_axi_bresp, s1_axi_bvalid,
           s1_axi_arready, s1_axi_rdata, s1_axi_rresp, s1_axi_rvalid
  );

endinterface

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - register array with one byte-strobed write port and one registered read port
module axil_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic                    rd_en_i,
  input  logic                    rd_hit_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read samples mem_q before this edge's write lands, so a same-edge read sees the old value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (wr_strb_i[b]) mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
      if (rd_en_i) rd_data_q <= rd_hit_i ? mem_q[rd_idx_i] : '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI4-Lite responder: write/read handshake FSMs, capture and decode over a register bank
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 8
) (
  input logic                 s1_axi_aclk,
  input logic                 s1_axi_areset,
  axil_slave_regfile_if.slave s1
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;
  localparam int BW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] REG_LIMIT = IW'(NUM_REGS);

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IW-1:0]         awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  bresp_q, bresp_d;

  r_state_e r_state_q, r_state_d;
  logic     rresp_q, rresp_d;

  logic                  awready, wready, aw_fire, w_fire, wr_en, wr_hit;
  logic [IW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic                  arready, rd_en, rd_hit;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      rresp_q   <= rresp_d;
    end
  end

  // Whichever half of the write pair arrives second completes it using the live bus value.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    awready   = 1'b0;
    wready    = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = aw_held_q ? awidx_q : s1.s1_axi_awaddr[ADDR_WIDTH-1:2];
    wr_data   = w_held_q ? wdata_q : s1.s1_axi_wdata;
    wr_strb   = w_held_q ? wstrb_q : s1.s1_axi_wstrb[SW-1:0];
    wr_hit    = wr_idx < REG_LIMIT;
    case (w_state_q)
      W_IDLE: begin
        awready = !aw_held_q;
        wready  = !w_held_q;
        aw_fire = s1.s1_axi_awvalid && awready;
        w_fire  = s1.s1_axi_wvalid && wready;
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          wr_en     = wr_hit;
          bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_fire) begin
            aw_held_d = 1'b1;
            awidx_d   = s1.s1_axi_awaddr[ADDR_WIDTH-1:2];
          end
          if (w_fire) begin
            w_held_d = 1'b1;
            wdata_d  = s1.s1_axi_wdata;
            wstrb_d  = s1.s1_axi_wstrb[SW-1:0];
          end
        end
      end
      W_RESP: if (s1.s1_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = s1.s1_axi_araddr[ADDR_WIDTH-1:2];
    rd_hit    = rd_idx < REG_LIMIT;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (s1.s1_axi_arvalid) begin
          rd_en     = 1'b1;
          rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: if (s1.s1_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  axil_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (BW)
  ) u_bank (
    .clk_i    (s1_axi_aclk),
    .rst_i    (s1_axi_areset),
    .wr_en_i  (wr_en),
    .wr_idx_i (wr_idx[BW-1:0]),
    .wr_data_i(wr_data),
    .wr_strb_i(wr_strb),
    .rd_en_i  (rd_en),
    .rd_hit_i (rd_hit),
    .rd_idx_i (rd_idx[BW-1:0]),
    .rd_data_o(rd_data)
  );

  assign s1.s1_axi_awready = awready;
  assign s1.s1_axi_wready  = wready;
  assign s1.s1_axi_bvalid  = (w_state_q == W_RESP);
  assign s1.s1_axi_bresp   = bresp_q;
  assign s1.s1_axi_arready = arready;
  assign s1.s1_axi_rvalid  = (r_state_q == R_DATA);
  assign s1.s1_axi_rresp   = rresp_q;
  assign s1.s1_axi_rdata   = rd_data;

  // Byte-lane address bits and the extra strobe bit carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s1.s1_axi_awaddr[1:0], s1.s1_axi_araddr[1:0], s1.s1_axi_wstrb[SW]};

endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - directed self-checking bench for axil_slave_regfile
module tb_axil_slave_regfile;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axil_slave_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  axil_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(8)) dut (
    .s1_axi_aclk  (clk),
    .s1_axi_areset(rst),
    .s1           (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                           output logic resp);
    logic aw_ok, w_ok;
    bus.s1_axi_awaddr  = addr;
    bus.s1_axi_wdata   = data;
    bus.s1_axi_wstrb   = strb;
    bus.s1_axi_awvalid = 1'b1;
    bus.s1_axi_wvalid  = 1'b1;
    bus.s1_axi_bready  = 1'b1;
    for (int i = 0; i < 20 && (bus.s1_axi_awvalid || bus.s1_axi_wvalid); i++) begin
      aw_ok = bus.s1_axi_awvalid && bus.s1_axi_awready;
      w_ok  = bus.s1_axi_wvalid && bus.s1_axi_wready;
      tick();
      if (aw_ok) bus.s1_axi_awvalid = 1'b0;
      if (w_ok)  bus.s1_axi_wvalid  = 1'b0;
    end
    chk("wr_accept", {30'd0, bus.s1_axi_awvalid, bus.s1_axi_wvalid}, 32'd0);
    for (int i = 0; i < 20 && !bus.s1_axi_bvalid; i++) tick();
    chk("wr_bvalid", {31'd0, bus.s1_axi_bvalid}, 32'd1);
    resp = bus.s1_axi_bresp;
    tick();
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic resp);
    logic ar_ok;
    bus.s1_axi_araddr  = addr;
    bus.s1_axi_arvalid = 1'b1;
    bus.s1_axi_rready  = 1'b1;
    for (int i = 0; i < 20 && bus.s1_axi_arvalid; i++) begin
      ar_ok = bus.s1_axi_arready;
      tick();
      if (ar_ok) bus.s1_axi_arvalid = 1'b0;
    end
    chk("rd_accept", {31'd0, bus.s1_axi_arvalid}, 32'd0);
    for (int i = 0; i < 20 && !bus.s1_axi_rvalid; i++) tick();
    chk("rd_rvalid", {31'd0, bus.s1_axi_rvalid}, 32'd1);
    data = bus.s1_axi_rdata;
    resp = bus.s1_axi_rresp;
    tick();
  endtask

  logic [31:0] exp_reg [8];
  logic [31:0] rd;
  logic        resp;

  initial begin
    bus.s1_axi_awaddr = '0; bus.s1_axi_awvalid = 1'b0;
    bus.s1_axi_wdata = '0;  bus.s1_axi_wstrb = '0; bus.s1_axi_wvalid = 1'b0;
    bus.s1_axi_bready = 1'b1;
    bus.s1_axi_araddr = '0; bus.s1_axi_arvalid = 1'b0; bus.s1_axi_rready = 1'b1;
    for (int i = 0; i < 8; i++) exp_reg[i] = 32'd0;

    // reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_bvalid", {31'd0, bus.s1_axi_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.s1_axi_rvalid}, 32'd0);
    chk("rst_readys", {29'd0, bus.s1_axi_awready, bus.s1_axi_wready, bus.s1_axi_arready}, 32'd7);
    chk("rst_rdata", bus.s1_axi_rdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      axi_read(8'(4*i), rd, resp);
      chk("rst_read", rd, 32'd0);
    end

    // AW and W on the same edge
    axi_write(8'h04, 32'h0000001E, 5'h0F, resp);
    chk("aw_w_bresp", {31'd0, resp}, 32'd0);
    exp_reg[1] = 32'h0000001E;
    axi_read(8'h04, rd, resp);
    chk("aw_w_read", rd, 32'h0000001E);

    // W one cycle ahead of AW
    for (int k = 0; k < 2; k++) begin
      bus.s1_axi_wdata  = (k == 0) ? 32'h25 : 32'h2C;
      bus.s1_axi_wstrb  = 5'h0F;
      bus.s1_axi_wvalid = 1'b1;
      tick();
      bus.s1_axi_wvalid = 1'b0;
      chk("w_first_held", {30'd0, bus.s1_axi_awready, bus.s1_axi_wready}, 32'd2);
      chk("w_first_nob", {31'd0, bus.s1_axi_bvalid}, 32'd0);
      bus.s1_axi_awaddr  = (k == 0) ? 8'h10 : 8'h14;
      bus.s1_axi_awvalid = 1'b1;
      tick();
      bus.s1_axi_awvalid = 1'b0;
      chk("w_first_b", {30'd0, bus.s1_axi_bvalid, bus.s1_axi_bresp}, 32'd2);
      tick();
    end
    exp_reg[4] = 32'h25;
    exp_reg[5] = 32'h2C;
    axi_read(8'h10, rd, resp);
    chk("w_first_rd10", rd, 32'h25);
    axi_read(8'h14, rd, resp);
    chk("w_first_rd14", rd, 32'h2C);

    // byte strobes: bytes 0 and 2 replaced
    axi_write(8'h00, 32'h11223344, 5'h0F, resp);
    axi_write(8'h00, 32'hAABBCCDD, 5'h05, resp);
    exp_reg[0] = 32'h11BB33DD;
    axi_read(8'h00, rd, resp);
    chk("strb_read", rd, 32'h11BB33DD);

    // all-zero strobe: OKAY, no change; strobe MSB is ignored
    axi_write(8'h04, 32'hFFFFFFFF, 5'h10, resp);
    chk("strb0_bresp", {31'd0, resp}, 32'd0);
    axi_read(8'h04, rd, resp);
    chk("strb0_read", rd, 32'h0000001E);

    // write response backpressure
    bus.s1_axi_bready  = 1'b0;
    bus.s1_axi_awaddr  = 8'h08; bus.s1_axi_wdata = 32'h5A; bus.s1_axi_wstrb = 5'h0F;
    bus.s1_axi_awvalid = 1'b1;  bus.s1_axi_wvalid = 1'b1;
    tick();
    bus.s1_axi_awvalid = 1'b0;  bus.s1_axi_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_b", {30'd0, bus.s1_axi_bvalid, bus.s1_axi_bresp}, 32'd2);
      chk("bp_awready", {30'd0, bus.s1_axi_awready, bus.s1_axi_wready}, 32'd0);
      tick();
    end
    bus.s1_axi_bready = 1'b1;
    tick();
    chk("bp_b_done", {30'd0, bus.s1_axi_bvalid, bus.s1_axi_awready}, 32'd1);
    exp_reg[2] = 32'h5A;

    // read data backpressure
    bus.s1_axi_rready  = 1'b0;
    bus.s1_axi_araddr  = 8'h08;
    bus.s1_axi_arvalid = 1'b1;
    tick();
    bus.s1_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", {30'd0, bus.s1_axi_rvalid, bus.s1_axi_arready}, 32'd2);
      chk("bp_rdata", bus.s1_axi_rdata, 32'h5A);
      tick();
    end
    bus.s1_axi_rready = 1'b1;
    tick();
    chk("bp_r_done", {30'd0, bus.s1_axi_rvalid, bus.s1_axi_arready}, 32'd1);

    // same-edge read and write of one register returns the old value
    bus.s1_axi_awaddr  = 8'h0C; bus.s1_axi_wdata = 32'h77; bus.s1_axi_wstrb = 5'h0F;
    bus.s1_axi_awvalid = 1'b1;  bus.s1_axi_wvalid = 1'b1;
    bus.s1_axi_araddr  = 8'h0C; bus.s1_axi_arvalid = 1'b1;
    tick();
    bus.s1_axi_awvalid = 1'b0;  bus.s1_axi_wvalid = 1'b0; bus.s1_axi_arvalid = 1'b0;
    chk("rw_same_rdata", bus.s1_axi_rdata, 32'd0);
    chk("rw_same_valid", {30'd0, bus.s1_axi_bvalid, bus.s1_axi_rvalid}, 32'd3);
    tick();
    exp_reg[3] = 32'h77;
    axi_read(8'h0C, rd, resp);
    chk("rw_same_after", rd, 32'h77);

    // out-of-range index
    axi_write(8'h20, 32'hDEADBEEF, 5'h0F, resp);
    chk("oor_bresp", {31'd0, resp}, 32'd1);
    axi_read(8'h20, rd, resp);
    chk("oor_rresp", {31'd0, resp}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    for (int i = 0; i < 8; i++) begin
      axi_read(8'(4*i), rd, resp);
      chk("oor_regs", rd, exp_reg[i]);
      chk("oor_regs_resp", {31'd0, resp}, 32'd0);
    end

    // reset in the middle of a pending response
    bus.s1_axi_bready  = 1'b0;
    bus.s1_axi_awaddr  = 8'h18; bus.s1_axi_wdata = 32'h99; bus.s1_axi_wstrb = 5'h0F;
    bus.s1_axi_awvalid = 1'b1;  bus.s1_axi_wvalid = 1'b1;
    tick();
    bus.s1_axi_awvalid = 1'b0;  bus.s1_axi_wvalid = 1'b0;
    chk("mid_rst_pre", {31'd0, bus.s1_axi_bvalid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.s1_axi_bready = 1'b1;
    chk("mid_rst_b", {31'd0, bus.s1_axi_bvalid}, 32'd0);
    axi_read(8'h18, rd, resp);
    chk("mid_rst_read", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
